// File: rtl/map9v3_sched_pkg.sv
// Shared types and helpers for the map9v3 request scheduler.
// Holds the FSM state enum, the dp/N width and the round-robin pick function.
package map9v3_sched_pkg;

  localparam int unsigned NW     = 9;
  localparam int unsigned MAXREQ = 8;

  typedef enum logic [2:0] {
    RST, BOOT, IDLE, START, WAITLO, WAITHI, RESP, TOUT
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or after ptr, wrapping within the lowest nreq bits.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [2:0]        ptr,
                                    input logic [3:0]        nreq);
    pick_t      p;
    logic [3:0] j;
    p = '0;
    for (int unsigned k = 0; k < MAXREQ; k++) begin
      j = {1'b0, ptr} + 4'(k);
      if (j >= nreq) j = j - nreq;
      if ((4'(k) < nreq) && !p.found && req[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/map9v3_rr_arb.sv
// Round-robin arbiter: combinational pick over NREQ requests with a registered
// pointer that moves past the winner whenever the parent accepts a grant.
module map9v3_rr_arb
  import map9v3_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic            o_found,
  output logic [2:0]      o_idx
);

  logic [2:0]        r_ptr;
  logic [MAXREQ-1:0] w_req;
  pick_t             w_pick;

  always_comb begin
    w_req             = '0;
    w_req[NREQ-1:0]   = i_req;
    w_pick            = rr_pick(w_req, r_ptr, 4'(NREQ));
  end

  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_ptr <= '0;
    end else if (i_advance && w_pick.found) begin
      r_ptr <= (w_pick.idx == 3'(NREQ - 1)) ? '0 : w_pick.idx + 3'd1;
    end
  end

endmodule

// File: rtl/map9v3_sched.sv
// Shares one map9v3 divisor-to-seed converter among NREQ requesters: round-robin
// grant, start/done sequencing, last-result cache and a run timeout.
module map9v3_sched
  import map9v3_sched_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TIMEOUT  = 600,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NW*NREQ-1:0] req_n,
  output logic [NREQ-1:0]    ack,
  output logic [NW-1:0]      rsp_dp,
  output logic               rsp_err,
  output logic               busy,
  output logic               map_reset,
  output logic               map_start,
  output logic [NW-1:0]      map_n,
  input  logic               map_done,
  input  logic [NW-1:0]      map_dp
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_grant;
  logic [NW-1:0]   r_map_n;
  logic [NW-1:0]   r_rsp_dp;
  logic            r_rsp_err;
  logic            r_cache_vld;
  logic [NW-1:0]   r_cache_n;
  logic [NW-1:0]   r_cache_dp;

  logic            w_found;
  logic [2:0]      w_idx;
  logic            w_advance;
  logic [NW-1:0]   w_sel_n;
  logic            w_hit;
  logic            w_tmo;

  map9v3_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk     (clock),
    .i_resetn  (resetn),
    .i_req     (req),
    .i_advance (w_advance),
    .o_found   (w_found),
    .o_idx     (w_idx)
  );

  always_comb begin
    w_sel_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_idx == 3'(i)) w_sel_n = req_n[i*NW +: NW];
    end
  end

  assign w_hit = CACHE_EN && r_cache_vld && (w_sel_n == r_cache_n);
  assign w_tmo = (r_cnt >= CW'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    unique case (r_state)
      RST:    w_next = BOOT;
      BOOT: begin
        if (map_done)   w_next = IDLE;
        else if (w_tmo) w_next = RST;
      end
      IDLE: begin
        if (w_found) begin
          w_advance = 1'b1;
          w_next    = w_hit ? RESP : START;
        end
      end
      START:  w_next = w_tmo ? TOUT : WAITLO;
      WAITLO: begin
        if (w_tmo)          w_next = TOUT;
        else if (!map_done) w_next = WAITHI;
      end
      // A done arriving in the same cycle as expiry still counts as success.
      WAITHI: begin
        if (map_done)   w_next = RESP;
        else if (w_tmo) w_next = TOUT;
      end
      RESP:   w_next = IDLE;
      TOUT:   w_next = RST;
      default: w_next = RST;
    endcase
  end

  always_comb begin
    ack = '0;
    if ((r_state == RESP) || (r_state == TOUT)) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (r_grant == 3'(i)) ack[i] = 1'b1;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign map_reset = (r_state == RST);
  assign map_start = (r_state == START);
  assign map_n     = r_map_n;
  assign rsp_dp    = r_rsp_dp;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= RST;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_map_n     <= '0;
      r_rsp_dp    <= '0;
      r_rsp_err   <= 1'b0;
      r_cache_vld <= 1'b0;
      r_cache_n   <= '0;
      r_cache_dp  <= '0;
    end else begin
      r_state <= w_next;

      // RST and IDLE precede BOOT and START, so clearing here clears on their entry.
      if ((r_state == RST) || (r_state == IDLE)) r_cnt <= '0;
      else if (r_cnt != '1)                     r_cnt <= r_cnt + 1'b1;

      if ((r_state == IDLE) && w_found) begin
        r_grant <= w_idx;
        if (w_hit) begin
          r_rsp_dp  <= r_cache_dp;
          r_rsp_err <= 1'b0;
        end else begin
          r_map_n   <= w_sel_n;
        end
      end

      if ((r_state == WAITHI) && map_done) begin
        r_rsp_dp    <= map_dp;
        r_rsp_err   <= 1'b0;
        r_cache_vld <= 1'b1;
        r_cache_n   <= r_map_n;
        r_cache_dp  <= map_dp;
      end

      if ((w_next == TOUT) && (r_state != TOUT)) begin
        r_rsp_dp    <= '0;
        r_rsp_err   <= 1'b1;
        r_cache_vld <= 1'b0;
      end
    end
  end

endmodule
